// File: rtl/arbiter_rr_4ph_if.sv
// Purpose: bundles the arbiter's requester-side and next-block-side handshake signals.
// Latency: none; this file only carries wires.
// Backpressure: none of its own; the four-phase req/ack pairs carry all flow control.
//
// Signals:
//   req_in    [N]     requests from the previous blocks
//   ack_in    [N]     acknowledges back to the previous blocks, at most one bit high
//   req_out   [1]     request to the next block
//   ack_out   [1]     acknowledge from the next block
//   sel       [SELW]  index of the granted requester, valid while busy
//   busy      [1]     arbiter is inside a handshake
//   proto_err [1]     sticky protocol-violation flag
// Modports: slave = arbiter side, master = environment side.
interface arbiter_rr_4ph_if #(
    parameter int N    = 4,
    parameter int SELW = (N > 2) ? $clog2(N) : 1
);
    logic [N-1:0]    req_in;
    logic [N-1:0]    ack_in;
    logic            req_out;
    logic            ack_out;
    logic [SELW-1:0] sel;
    logic            busy;
    logic            proto_err;

    modport slave (
        input  req_in,
        input  ack_out,
        output ack_in,
        output req_out,
        output sel,
        output busy,
        output proto_err
    );

    modport master (
        output req_in,
        output ack_out,
        input  ack_in,
        input  req_out,
        input  sel,
        input  busy,
        input  proto_err
    );
endinterface

// File: rtl/arbiter_rr_4ph.sv
// Purpose: N-way round-robin arbiter forwarding the winner's four-phase req/ack handshake to one shared next block.
// Latency: one clock from a request seen in IDLE to req_out high; every output is a flop.
// Backpressure: the grant is held until the next block finishes its four-phase cycle; losers wait with req held high.
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset; aborts any handshake in flight
//   bus  slave modport of arbiter_rr_4ph_if (req_in, ack_out in; ack_in, req_out, sel, busy, proto_err out)
module arbiter_rr_4ph #(
    parameter int N    = 4,
    parameter int SELW = (N > 2) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    arbiter_rr_4ph_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_ptr_nxt;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] w_sel_nxt;
    logic [N-1:0]    r_ack_in;
    logic [N-1:0]    w_ack_in_nxt;
    logic            r_req_out;
    logic            w_req_out_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_proto_err;
    logic            w_proto_err_nxt;

    logic [SELW-1:0] w_winner;
    logic            w_any_req;
    logic [SELW-1:0] w_scan_idx;
    int              w_scan_sum;
    logic [N-1:0]    w_sel_onehot;
    logic [SELW-1:0] w_sel_inc;

    // Rotating scan starting at r_ptr. The loop walks the offsets from the
    // far end back towards r_ptr, so the last hit written is the one closest
    // to r_ptr, i.e. the first set bit in ptr, ptr+1, ..., ptr-1 order.
    always_comb begin
        w_winner   = '0;
        w_any_req  = 1'b0;
        w_scan_sum = 0;
        w_scan_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_scan_sum = (int'(r_ptr) + i) % N;
            w_scan_idx = SELW'(w_scan_sum);
            if (bus.req_in[w_scan_idx]) begin
                w_winner  = w_scan_idx;
                w_any_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_onehot        = '0;
        w_sel_onehot[r_sel] = 1'b1;
    end

    // Pointer advance with explicit wrap, so non-power-of-two N works too.
    assign w_sel_inc = (r_sel == SELW'(N - 1)) ? '0 : (r_sel + SELW'(1));

    // Next-state and next-output logic. Protocol violations only raise the
    // sticky flag; they never redirect the state machine.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_sel_nxt       = r_sel;
        w_ack_in_nxt    = r_ack_in;
        w_req_out_nxt   = r_req_out;
        w_busy_nxt      = r_busy;
        w_proto_err_nxt = r_proto_err;

        unique case (r_state)
            ST_IDLE: begin
                // The next block must not acknowledge a request we never made.
                if (bus.ack_out) begin
                    w_proto_err_nxt = 1'b1;
                end
                if (w_any_req) begin
                    w_state_nxt   = ST_GRANT;
                    w_sel_nxt     = w_winner;
                    w_req_out_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                end
            end

            ST_GRANT: begin
                // The winner withdrew before being acknowledged.
                if (!bus.req_in[r_sel]) begin
                    w_proto_err_nxt = 1'b1;
                end
                if (bus.ack_out) begin
                    w_state_nxt  = ST_ACK;
                    w_ack_in_nxt = w_sel_onehot;
                end
            end

            ST_ACK: begin
                // ack_out was high on entry, so low here means it fell early.
                if (!bus.ack_out) begin
                    w_proto_err_nxt = 1'b1;
                end
                if (!bus.req_in[r_sel]) begin
                    w_state_nxt   = ST_RELEASE;
                    w_req_out_nxt = 1'b0;
                end
            end

            ST_RELEASE: begin
                // ack_in[sel] stays high until the next block has let go, which
                // closes the requester's return-to-zero phase.
                if (!bus.ack_out) begin
                    w_state_nxt  = ST_IDLE;
                    w_ack_in_nxt = '0;
                    w_busy_nxt   = 1'b0;
                    w_ptr_nxt    = w_sel_inc;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_ack_in    <= '0;
            r_req_out   <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_ack_in    <= w_ack_in_nxt;
            r_req_out   <= w_req_out_nxt;
            r_busy      <= w_busy_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    assign bus.ack_in    = r_ack_in;
    assign bus.req_out   = r_req_out;
    assign bus.sel       = r_sel;
    assign bus.busy      = r_busy;
    assign bus.proto_err = r_proto_err;

endmodule
